uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters (fixed range 2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 1200, SHALL set the watchdog limit in clk cycles (used only under REQ-026).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 req  input  NUM_REQ  SHALL carry per-requester transmit requests, held high until the matching ack.
REQ-006 req_data  input  8*NUM_REQ  SHALL carry per-requester bytes; requester i occupies bits [8i+7:8i].
REQ-007 ack  output  NUM_REQ  SHALL be a one-hot, one-cycle completion pulse to the served requester.
REQ-008 tx_data  output  8  SHALL drive the uart_tx input byte.
REQ-009 tx_dv  output  1  SHALL drive the uart_tx data-valid strobe.
REQ-010 tx_done  input  1  SHALL receive the uart_tx done signal.
REQ-011 busy  output  1  SHALL be high in every state except IDLE.
REQ-012 tx_err  output  1  SHALL be the sticky watchdog error flag.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, LAUNCH, WAIT_DONE, ACK.
REQ-014 IDLE: if any req bit is high, the FSM SHALL select the winner by round-robin starting at pointer rr_ptr, latch its byte into tx_data and its index into grant_idx, and go to LAUNCH on the next edge.
REQ-015 LAUNCH: tx_dv SHALL be high for exactly this one cycle; the next state SHALL be WAIT_DONE.
REQ-016 WAIT_DONE: the first cycle with tx_done high SHALL move the FSM to ACK; tx_dv SHALL stay low.
REQ-017 ACK: ack[grant_idx] SHALL be high for this one cycle, rr_ptr SHALL become (grant_idx+1) mod NUM_REQ, and the next state SHALL be IDLE.
REQ-018 Latency from req rising in IDLE to tx_dv SHALL be 2 cycles (one edge to latch, tx_dv high in the following cycle).
REQ-019 tx_data SHALL hold the latched byte from the IDLE capture edge until the next capture; req_data changes after capture SHALL be ignored.
REQ-020 A winner's req dropping before ack SHALL NOT abort the transfer; ack SHALL still pulse.
REQ-021 tx_done while in IDLE, LAUNCH or ACK SHALL be ignored.
REQ-022 A requester that holds req high after its ack SHALL be re-eligible only after all other pending requesters in round-robin order.
REQ-023 rr_ptr arithmetic SHALL wrap from NUM_REQ-1 to 0.
REQ-024 At most one ack bit SHALL be high in any cycle; ack and tx_dv SHALL never be high in the same cycle.

Reset
REQ-025 When rst is high at a rising edge, the block SHALL enter IDLE with tx_dv=0, ack=0, tx_data=8'h00, busy=0, tx_err=0, rr_ptr=0 and the watchdog count=0, regardless of current state (including mid-transfer); rst SHALL take priority over every other input.

Configuration
REQ-026 Macro UART_ARB_TIMEOUT_EN defined: the block SHALL count cycles in WAIT_DONE; if the count reaches TIMEOUT_CYCLES without tx_done, the FSM SHALL go to ACK (ack pulses normally), set tx_err=1 until reset, and clear the count on every entry to WAIT_DONE.
REQ-027 Macro UART_ARB_TIMEOUT_EN undefined: the block SHALL contain no watchdog counter, tx_err SHALL be tied 0, and WAIT_DONE SHALL wait indefinitely for tx_done.

Verification
REQ-028 Single requester: req=4'b0001, req_data[7:0]=8'h69 -> tx_dv is high for 1 cycle 2 cycles later with tx_data=8'h69; ack=4'b0001 is high 1 cycle after tx_done; busy is low afterwards.
REQ-029 Contention: req=4'b1111 held, bytes 8'hA0..8'hA3 -> tx_data sequence is A0, A1, A2, A3, A0 with acks in order 0, 1, 2, 3, 0.
REQ-030 Wrap and fairness: after serving requester 3, req=4'b1001 -> requester 0 is served next, then 3.
REQ-031 Mid-transfer reset: rst high during WAIT_DONE -> the next cycle shows IDLE, busy=0, no ack pulse, and rr_ptr=0.
REQ-032 Timeout (macro defined, TIMEOUT_CYCLES=50, tx_done held low) -> ack pulses after 50 WAIT_DONE cycles and tx_err=1 stays set until rst; with the macro undefined -> the block stays busy with tx_err=0.
REQ-033 Late data change: req_data altered 1 cycle after capture -> tx_data keeps the originally captured byte through ack.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between N byte requesters, the arbiter and a downstream uart_tx.
// The master modport is the requester/uart side and the slave modport is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic [7:0]           tx_data;
  logic                 tx_dv;
  logic                 tx_done;
  logic                 busy;
  logic                 tx_err;

  modport master (
    output req, req_data, tx_done,
    input  ack, tx_data, tx_dv, busy, tx_err
  );

  modport slave (
    input  req, req_data, tx_done,
    output ack, tx_data, tx_dv, busy, tx_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one uart_tx from NUM_REQ byte requesters.
// Define UART_ARB_TIMEOUT_EN to add a WAIT_DONE watchdog that forces ACK and sets tx_err.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1200
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : gen_bad_param
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {StIdle, StLaunch, StWaitDone, StAck} state_e;

  state_e               state_q;
  logic [IdxW-1:0]      rr_ptr_q;
  logic [IdxW-1:0]      grant_idx_q;
  logic [7:0]           tx_data_q;
  logic                 tx_dv_q;
  logic [NUM_REQ-1:0]   ack_q;

  logic                 win_found;
  logic [IdxW-1:0]      win_idx;
  logic [7:0]           win_byte;
  logic [IdxW-1:0]      cand_idx;
  int unsigned          cand;
  logic [IdxW-1:0]      rr_next;

  // Scan requesters starting at rr_ptr_q; the first asserted one wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_byte  = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IdxW'(cand);
      if (!win_found && bus.req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
        win_byte  = bus.req_data[{cand_idx, 3'b000} +: 8];
      end
    end
  end

  always_comb begin
    rr_next = (grant_idx_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdW-1:0] wd_cnt_q;
  logic           tx_err_q;
  logic           wd_expired;

  // The cycle in which the count reaches TIMEOUT_CYCLES-1 is the last WAIT_DONE cycle.
  assign wd_expired  = (wd_cnt_q == WdW'(TIMEOUT_CYCLES - 1));
  assign bus.tx_err  = tx_err_q;
`else
  assign bus.tx_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      tx_data_q   <= 8'h00;
      tx_dv_q     <= 1'b0;
      ack_q       <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      wd_cnt_q    <= '0;
      tx_err_q    <= 1'b0;
`endif
    end else begin
      tx_dv_q <= 1'b0;
      ack_q   <= '0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            grant_idx_q <= win_idx;
            tx_data_q   <= win_byte;
            tx_dv_q     <= 1'b1;
            state_q     <= StLaunch;
          end
        end
        StLaunch: begin
          state_q  <= StWaitDone;
`ifdef UART_ARB_TIMEOUT_EN
          wd_cnt_q <= '0;
`endif
        end
        StWaitDone: begin
`ifdef UART_ARB_TIMEOUT_EN
          if (bus.tx_done || wd_expired) begin
            ack_q   <= NUM_REQ'(1) << grant_idx_q;
            state_q <= StAck;
            if (!bus.tx_done) tx_err_q <= 1'b1;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
`else
          if (bus.tx_done) begin
            ack_q   <= NUM_REQ'(1) << grant_idx_q;
            state_q <= StAck;
          end
`endif
        end
        StAck: begin
          rr_ptr_q <= rr_next;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.tx_data = tx_data_q;
  assign bus.tx_dv   = tx_dv_q;
  assign bus.ack     = ack_q;
  assign bus.busy    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected transfers, a monitor checks
// every tx_dv launch and ack pulse. Build with UART_ARB_TIMEOUT_EN to cover the watchdog.
module tb_uart_tx_arbiter;
  localparam int unsigned NReq = 4;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned ToCycles = 50;
`else
  localparam int unsigned ToCycles = 1200;
`endif
  localparam int Budget = 200;

  typedef struct packed {
    logic [3:0] ack;
    logic [7:0] data;
  } xfer_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NReq)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ       (NReq),
    .TIMEOUT_CYCLES(ToCycles)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int    tests = 0;
  int    fails = 0;
  xfer_t exp_q[$];
  xfer_t pend;
  logic  pend_v = 1'b0;
  logic  uart_auto = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event not as required (t=%0t)", name, $time);
  endtask

  task automatic push(input logic [3:0] a, input logic [7:0] d);
    xfer_t x;
    x.ack  = a;
    x.data = d;
    exp_q.push_back(x);
  endtask

  task automatic wait_txdv();
    int cyc = 0;
    do begin @(negedge clk); cyc++; end while (bus.tx_dv !== 1'b1 && cyc < Budget);
    if (bus.tx_dv !== 1'b1) fail_evt("tx_dv_wait_expired");
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (bus.ack === '0 && cyc < Budget);
    if (bus.ack === '0) fail_evt("ack_wait_expired");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_tx_dv", bus.tx_dv, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_tx_err", bus.tx_err, 0);
    pend_v = 1'b0;
    rst = 1'b0;
  endtask

  // Simple uart_tx model: done pulse three cycles after each launch.
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_dv === 1'b1 && uart_auto) begin
        repeat (3) @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on launch, matches the ack against the popped entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_dv === 1'b1) begin
        if (exp_q.size() == 0) begin
          fail_evt("unexpected_tx_dv");
        end else begin
          pend = exp_q.pop_front();
          check("tx_data_at_launch", bus.tx_data, pend.data);
          pend_v = 1'b1;
        end
      end
      if (bus.ack !== '0) begin
        check("ack_without_tx_dv", bus.tx_dv, 0);
        if (!pend_v) begin
          fail_evt("unexpected_ack");
        end else begin
          check("ack_bits", bus.ack, pend.ack);
          check("tx_data_at_ack", bus.tx_data, pend.data);
          pend_v = 1'b0;
        end
      end
    end
  end

  initial begin
    int cyc;
    bus.req      = '0;
    bus.req_data = '0;
    do_reset();

    // Single requester with launch latency and pulse widths.
    @(negedge clk);
    bus.req_data[7:0] = 8'h69;
    bus.req = 4'b0001;
    push(4'b0001, 8'h69);
    @(negedge clk);
    check("single_tx_dv_latency", bus.tx_dv, 1);
    check("single_busy", bus.busy, 1);
    @(negedge clk);
    check("single_tx_dv_one_cycle", bus.tx_dv, 0);
    wait_ack(cyc);
    bus.req = 4'b0000;
    @(negedge clk);
    check("single_ack_one_cycle", bus.ack, 0);
    check("single_busy_after", bus.busy, 0);

    // Full contention from pointer 0.
    do_reset();
    bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.req = 4'b1111;
    push(4'b0001, 8'hA0);
    push(4'b0010, 8'hA1);
    push(4'b0100, 8'hA2);
    push(4'b1000, 8'hA3);
    push(4'b0001, 8'hA0);
    for (int i = 0; i < 5; i++) wait_ack(cyc);
    bus.req = 4'b0000;

    // Serve 3 to wrap the pointer, then 0 before 3 again.
    @(negedge clk);
    bus.req_data[31:24] = 8'hB3;
    bus.req = 4'b1000;
    push(4'b1000, 8'hB3);
    wait_ack(cyc);
    bus.req_data = {8'hC3, 8'h00, 8'h00, 8'hC0};
    bus.req = 4'b1001;
    push(4'b0001, 8'hC0);
    push(4'b1000, 8'hC3);
    wait_ack(cyc);
    bus.req = 4'b1000;
    wait_ack(cyc);
    bus.req = 4'b0000;

    // Data change and req drop right after capture.
    @(negedge clk);
    bus.req_data[23:16] = 8'hD2;
    bus.req = 4'b0100;
    push(4'b0100, 8'hD2);
    @(negedge clk);
    bus.req_data[23:16] = 8'hEE;
    bus.req = 4'b0000;
    wait_ack(cyc);
    @(negedge clk);
    check("late_change_idle", bus.busy, 0);

    // Stray tx_done while idle.
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    check("stray_done_busy", bus.busy, 0);
    @(negedge clk);
    check("stray_done_ack", bus.ack, 0);

    // uart never answers.
    uart_auto = 1'b0;
    bus.req_data[15:8] = 8'h5A;
    bus.req = 4'b0010;
    push(4'b0010, 8'h5A);
    wait_txdv();
`ifdef UART_ARB_TIMEOUT_EN
    wait_ack(cyc);
    check("timeout_ack_latency", cyc, 51);
    check("timeout_tx_err", bus.tx_err, 1);
    bus.req = 4'b0000;
    repeat (5) @(negedge clk);
    check("timeout_err_sticky", bus.tx_err, 1);
    bus.req_data[23:16] = 8'h77;
    bus.req = 4'b0100;
    push(4'b0100, 8'h77);
    wait_txdv();
    bus.req = 4'b0000;
    repeat (3) @(negedge clk);
`else
    bus.req = 4'b0000;
    repeat (60) @(negedge clk);
    check("no_timeout_busy", bus.busy, 1);
    check("no_timeout_tx_err", bus.tx_err, 0);
`endif

    // Reset in WAIT_DONE drops the transfer and the pointer.
    check("mid_rst_pre_busy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ack", bus.ack, 0);
    check("mid_rst_tx_err", bus.tx_err, 0);
    pend_v = 1'b0;
    rst = 1'b0;
    uart_auto = 1'b1;
    bus.req_data = {8'hF3, 8'hF2, 8'hF1, 8'hF0};
    bus.req = 4'b1111;
    push(4'b0001, 8'hF0);
    wait_ack(cyc);
    bus.req = 4'b0000;
    repeat (3) @(negedge clk);
    check("final_busy", bus.busy, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end
endmodule
